led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 206 ++++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Shared blink-waveform source for the per-LED output mux. A prescaler divides
// clk into a tick; a blink counter produces the symmetric slow blink
// (pattern1) and a five-state FSM (IDLE, ON1, OFF1, ON2, OFF2) produces the
// heartbeat double flash (pattern2). All state is registered; outputs come
// straight from registers (optionally ANDed with a PWM dimming gate).
//
// Optional feature macro: LED_PATTERN_DIM_EN
//   defined   -> pattern1/pattern2 are gated by (pwm_cnt <= dim), where
//                pwm_cnt is a free-running 4-bit counter cleared by rst.
//   undefined -> dim is ignored; outputs are the raw pattern registers.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   enable      in   run generators; low holds the reset state
//   sync        in   single-cycle restart to phase 0
//   dim[3:0]    in   brightness level (dim build only)
//   pattern1    out  slow symmetric blink
//   pattern2    out  heartbeat double flash
//   tick        out  one-cycle pulse every TICK_DIV cycles while running
//   frame_start out  one-cycle pulse at each entry to ON1
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_HALF  = 250,
  parameter int FLASH_TICKS = 60,
  parameter int GAP_TICKS   = 120,
  parameter int PAUSE_TICKS = 760
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sync,
  input  logic [3:0] dim,
  output logic       pattern1,
  output logic       pattern2,
  output logic       tick,
  output logic       frame_start
);

  // Elaboration-time parameter range checks.
  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("led_pattern_gen: TICK_DIV must be in 2..65535");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 65535) begin : g_bad_blink_half
    $error("led_pattern_gen: BLINK_HALF must be in 1..65535");
  end
  if (FLASH_TICKS < 1 || FLASH_TICKS > 65535) begin : g_bad_flash
    $error("led_pattern_gen: FLASH_TICKS must be in 1..65535");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > 65535) begin : g_bad_gap
    $error("led_pattern_gen: GAP_TICKS must be in 1..65535");
  end
  if (PAUSE_TICKS < 1 || PAUSE_TICKS > 65535) begin : g_bad_pause
    $error("led_pattern_gen: PAUSE_TICKS must be in 1..65535");
  end

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ON1  = 3'd1;
  localparam logic [2:0] OFF1 = 3'd2;
  localparam logic [2:0] ON2  = 3'd3;
  localparam logic [2:0] OFF2 = 3'd4;

  // Terminal counts: each counter clears on the tick where it hits N-1.
  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);
  localparam logic [15:0] FLASH_LAST = 16'(FLASH_TICKS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_TICKS - 1);
  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_TICKS - 1);

  logic [15:0] presc_r,  presc_next_s;
  logic [15:0] blink_r,  blink_next_s;
  logic [15:0] phase_r,  phase_next_s;
  logic [2:0]  state_r,  state_next_s;
  logic        pattern1_r, pattern1_next_s;
  logic        pattern2_r, pattern2_next_s;
  logic        tick_r,     tick_next_s;
  logic        frame_r,    frame_next_s;
  logic        wrap_s;
  logic        start_s;
  logic [15:0] dur_last_s;

  // Terminal phase count for the current heartbeat state.
  always_comb begin
    case (state_r)
      ON1:     dur_last_s = FLASH_LAST;
      OFF1:    dur_last_s = GAP_LAST;
      ON2:     dur_last_s = FLASH_LAST;
      OFF2:    dur_last_s = PAUSE_LAST;
      default: dur_last_s = 16'd0;
    endcase
  end

  // Next-state logic: clear > start/sync > tick-driven advance.
  always_comb begin
    wrap_s          = (presc_r == TICK_LAST);
    start_s         = enable && ((state_r == IDLE) || sync);
    presc_next_s    = presc_r;
    blink_next_s    = blink_r;
    phase_next_s    = phase_r;
    state_next_s    = state_r;
    pattern1_next_s = pattern1_r;
    tick_next_s     = 1'b0;
    frame_next_s    = 1'b0;

    if (rst || !enable) begin
      presc_next_s    = 16'd0;
      blink_next_s    = 16'd0;
      phase_next_s    = 16'd0;
      state_next_s    = IDLE;
      pattern1_next_s = 1'b0;
    end else if (start_s) begin
      // A start discards any coincident tick action.
      presc_next_s    = 16'd0;
      blink_next_s    = 16'd0;
      phase_next_s    = 16'd0;
      state_next_s    = ON1;
      pattern1_next_s = 1'b1;
      frame_next_s    = 1'b1;
    end else if (wrap_s) begin
      presc_next_s = 16'd0;
      tick_next_s  = 1'b1;

      if (blink_r == BLINK_LAST) begin
        blink_next_s    = 16'd0;
        pattern1_next_s = !pattern1_r;
      end else begin
        blink_next_s = blink_r + 16'd1;
      end

      if (phase_r == dur_last_s) begin
        phase_next_s = 16'd0;
        case (state_r)
          ON1:  state_next_s = OFF1;
          OFF1: state_next_s = ON2;
          ON2:  state_next_s = OFF2;
          OFF2: begin
            state_next_s = ON1;
            frame_next_s = 1'b1;
          end
          default: state_next_s = IDLE;
        endcase
      end else begin
        phase_next_s = phase_r + 16'd1;
      end
    end else begin
      presc_next_s = presc_r + 16'd1;
    end

    // Moore decode of the next state so pattern2 is a clean register.
    pattern2_next_s = (state_next_s == ON1) || (state_next_s == ON2);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r    <= 16'd0;
      blink_r    <= 16'd0;
      phase_r    <= 16'd0;
      state_r    <= IDLE;
      pattern1_r <= 1'b0;
      pattern2_r <= 1'b0;
      tick_r     <= 1'b0;
      frame_r    <= 1'b0;
    end else begin
      presc_r    <= presc_next_s;
      blink_r    <= blink_next_s;
      phase_r    <= phase_next_s;
      state_r    <= state_next_s;
      pattern1_r <= pattern1_next_s;
      pattern2_r <= pattern2_next_s;
      tick_r     <= tick_next_s;
      frame_r    <= frame_next_s;
    end
  end

  assign tick        = tick_r;
  assign frame_start = frame_r;

`ifdef LED_PATTERN_DIM_EN
  logic [3:0] pwm_cnt_r;
  logic       gate_s;

  // Free-running PWM counter for dimming; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
    end
  end

  assign gate_s   = (pwm_cnt_r <= dim);
  assign pattern1 = pattern1_r & gate_s;
  assign pattern2 = pattern2_r & gate_s;
`else
  logic unused_dim_s;
  assign unused_dim_s = ^dim;
  assign pattern1     = pattern1_r;
  assign pattern2     = pattern2_r;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen. The reference model tracks only
// "running" and the number of cycles t since the last start edge, and derives
// every output from the waveform rules with plain arithmetic.
module tb_led_pattern_gen;

  localparam int TD  = 4;
  localparam int BH  = 3;
  localparam int FL  = 1;
  localparam int GP  = 2;
  localparam int PS  = 4;
  localparam int PER = 2 * FL + GP + PS;   // heartbeat period in ticks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] dim = 4'd15;
  logic       pattern1, pattern2, tick, frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit         running = 1'b0;
  int         t = 0;
  logic [3:0] pwm = 4'd0;

  led_pattern_gen #(
    .TICK_DIV(TD), .BLINK_HALF(BH), .FLASH_TICKS(FL),
    .GAP_TICKS(GP), .PAUSE_TICKS(PS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .dim(dim),
    .pattern1(pattern1), .pattern2(pattern2), .tick(tick),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected {pattern1, pattern2, tick, frame_start} from the model.
  function automatic logic [3:0] expected();
    logic p1, p2, tk, fs;
    int m;
    if (!running) return 4'b0000;
    p1 = ((t / (BH * TD)) % 2) == 0;
    m  = (t / TD) % PER;
    p2 = (m < FL) || (m >= FL + GP && m < 2 * FL + GP);
    tk = (t > 0) && (t % TD == 0);
    fs = (t % (PER * TD)) == 0;
`ifdef LED_PATTERN_DIM_EN
    if (!(pwm <= dim)) begin
      p1 = 1'b0;
      p2 = 1'b0;
    end
`endif
    return {p1, p2, tk, fs};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) pwm = 4'd0;
    else     pwm = pwm + 4'd1;
    if (rst || !enable) begin
      running = 1'b0;
      t = 0;
    end else if (!running || sync) begin
      running = 1'b1;
      t = 0;
    end else begin
      t = t + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset: got %b want 0000", {pattern1, pattern2, tick, frame_start});
      end
    end
    sync = 1'b0; enable = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_start_and_free_run();
    enable = 1'b1;
    cycle();
    n_tests++;
    if ({pattern1, pattern2, frame_start} !== 3'b111) begin
      n_fail++;
      $display("FAIL start_edge: got p1p2fs=%b want 111", {pattern1, pattern2, frame_start});
    end
    for (int i = 0; i < 200; i++) begin
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== expected()) begin
        n_fail++;
        $display("FAIL free_run t=%0d: got %b want %b", t,
                 {pattern1, pattern2, tick, frame_start}, expected());
      end
    end
  endtask

  task automatic test_sync();
    // Restart cleanly, then sync at t=18.
    enable = 1'b0; cycle(); enable = 1'b1; cycle();
    while (t < 17) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    n_tests++;
    if ({pattern1, pattern2, tick, frame_start} !== 4'b1101) begin
      n_fail++;
      $display("FAIL sync_restart: got %b want 1101", {pattern1, pattern2, tick, frame_start});
    end
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== expected()) begin
        n_fail++;
        $display("FAIL after_sync t=%0d: got %b want %b", t,
                 {pattern1, pattern2, tick, frame_start}, expected());
      end
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0; cycle(); enable = 1'b1; cycle();
    while (t < 13) cycle();   // ON2 spans t=12..15
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== 4'b0000) begin
        n_fail++;
        $display("FAIL enable_low: got %b want 0000", {pattern1, pattern2, tick, frame_start});
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== expected()) begin
        n_fail++;
        $display("FAIL restart t=%0d: got %b want %b", t,
                 {pattern1, pattern2, tick, frame_start}, expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 59) != 0);
      sync   = ($urandom_range(0, 49) == 0);
      dim    = 4'($urandom_range(0, 15));
      cycle();
      n_tests++;
      if ({pattern1, pattern2, tick, frame_start} !== expected()) begin
        n_fail++;
        $display("FAIL random i=%0d t=%0d: got %b want %b", i, t,
                 {pattern1, pattern2, tick, frame_start}, expected());
      end
    end
    rst = 1'b0; sync = 1'b0; enable = 1'b1; dim = 4'd15;
  endtask

  task automatic test_rst_with_sync();
    rst = 1'b1; sync = 1'b1; enable = 1'b1;
    cycle();
    n_tests++;
    if ({pattern1, pattern2, tick, frame_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_sync: got %b want 0000", {pattern1, pattern2, tick, frame_start});
    end
    rst = 1'b0; sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_and_free_run();
    test_sync();
    test_enable_drop();
    test_rst_with_sync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
